// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FETCH/HOLD controller that fetches one word per handshake
// into an instruction register, with PC increment, wrap and branch redirect at handshake.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned OPERAND_WIDTH = 11
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                imem_req,
  output logic [ADDR_WIDTH-1:0]               imem_addr,
  input  logic                                imem_ack,
  input  logic [DATA_WIDTH-1:0]               imem_rdata,
  output logic                                ir_valid,
  input  logic                                ir_ready,
  output logic [DATA_WIDTH-OPERAND_WIDTH-1:0] ir_opcode,
  output logic [OPERAND_WIDTH-1:0]            ir_operand,
  output logic [ADDR_WIDTH-1:0]               ir_pc,
  input  logic                                branch_en,
  input  logic [ADDR_WIDTH-1:0]               branch_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic [ADDR_WIDTH-1:0]   ir_pc_q, ir_pc_d;
  logic                    imem_req_q, imem_req_d;
  logic                    ir_valid_q, ir_valid_d;

  // Next-state, PC and IR update; req/valid are registered decodes of the next state
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    imem_req_d = 1'b0;
    ir_valid_d = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          ir_pc_d = pc_q;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ir_ready) begin
          state_d = FETCH;
          if (branch_en) pc_d = branch_target;
        end
      end
      default: state_d = IDLE;
    endcase
    imem_req_d = (state_d == FETCH);
    ir_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      imem_req_q <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      imem_req_q <= imem_req_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ir_valid   = ir_valid_q;
  assign ir_opcode  = ir_q[DATA_WIDTH-1:OPERAND_WIDTH];
  assign ir_operand = ir_q[OPERAND_WIDTH-1:0];
  assign ir_pc      = ir_pc_q;

endmodule
